// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M/RV64M multiply/divide execution unit.
//               One operation in flight at a time; valid/ready on both sides.
//               Multiply is shift-add over operand magnitudes and divide is
//               restoring division over magnitudes. The sign is applied in
//               the FIX state. Divide-by-zero, signed overflow and zero
//               multiplies bypass the iteration and complete in one cycle.
//               Optional macro MULDIV_FAST_MUL_EN: the four multiply ops use a
//               single-cycle product and skip the iteration; divides are
//               unchanged.
// Ports       : clk, rst (async, active-high), flush (sync abort)
//               in_valid/in_ready, op[2:0], src_a, src_b  - request
//               out_valid/out_ready, result               - response
//               busy                                      - not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("mul_div_unit: XLEN must be 32 or 64");
    end

    localparam logic [2:0] c_op_mul    = 3'd0;
    localparam logic [2:0] c_op_mulh   = 3'd1;
    localparam logic [2:0] c_op_mulhsu = 3'd2;
    localparam logic [2:0] c_op_mulhu  = 3'd3;
    localparam logic [2:0] c_op_div    = 3'd4;
    localparam logic [2:0] c_op_divu   = 3'd5;
    localparam logic [2:0] c_op_rem    = 3'd6;
    localparam logic [2:0] c_op_remu   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_hi;      // mul: product high half / div: remainder
    logic [XLEN-1:0]   r_lo;      // mul: multiplier shifting out / div: dividend in, quotient out
    logic [XLEN-1:0]   r_opnd;    // mul: multiplicand magnitude / div: divisor magnitude
    logic [XLEN-1:0]   r_result;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_res_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;

    assign w_accept   = in_valid && (r_state == S_IDLE) && !flush;
    assign w_is_div   = op[2];
    assign w_a_signed = (op == c_op_mulh) || (op == c_op_mulhsu) ||
                        (op == c_op_div)  || (op == c_op_rem);
    assign w_b_signed = (op == c_op_mulh) || (op == c_op_div) || (op == c_op_rem);
    assign w_a_neg    = w_a_signed && src_a[XLEN-1];
    assign w_b_neg    = w_b_signed && src_b[XLEN-1];
    assign w_abs_a    = w_a_neg ? -src_a : src_a;
    assign w_abs_b    = w_b_neg ? -src_b : src_b;
    // Remainder follows the dividend sign; every other signed result is a^b.
    // MUL keeps both flags clear: its low half is sign-agnostic.
    assign w_res_neg  = (op == c_op_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);

    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        if (w_is_div) begin
            if (src_b == '0) begin
                w_special     = 1'b1;
                w_special_res = op[1] ? src_a : '1;
            end else if (!op[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b)) begin
                w_special     = 1'b1;
                w_special_res = op[1] ? '0 : src_a;
            end
        end else if ((src_a == '0) || (src_b == '0)) begin
            w_special = 1'b1;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extend both operands to full product width so an unsigned
    // 2*XLEN multiply yields the correct signed/unsigned product.
    logic [2*XLEN-1:0] w_fa;
    logic [2*XLEN-1:0] w_fb;
    logic [2*XLEN-1:0] w_fprod;
    assign w_fa       = {{XLEN{w_a_neg}}, src_a};
    assign w_fb       = {{XLEN{w_b_neg}}, src_b};
    assign w_fprod    = w_fa * w_fb;
    assign w_fast     = !w_is_div;
    assign w_fast_res = (op == c_op_mul) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_res;

    assign w_addend    = r_lo[0] ? r_opnd : '0;
    assign w_mul_sum   = {1'b0, r_hi} + {1'b0, w_addend};
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    // Top bit set means the trial subtraction went negative (restore).
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

    assign w_prod      = {r_hi, r_lo};
    assign w_prod_fix  = r_neg ? -w_prod : w_prod;
    assign w_quo_fix   = r_neg ? -r_lo : r_lo;
    assign w_rem_fix   = r_neg ? -r_hi : r_hi;

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            c_op_mul:                           w_fix_res = w_prod_fix[XLEN-1:0];
            c_op_mulh, c_op_mulhsu, c_op_mulhu: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
            c_op_div, c_op_divu:                w_fix_res = w_quo_fix;
            c_op_rem, c_op_remu:                w_fix_res = w_rem_fix;
            default:                            w_fix_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) w_state_next = (w_special || w_fast) ? S_DONE : S_CALC;
                S_CALC: if (r_cnt == CNT_W'(1)) w_state_next = S_FIX;
                S_FIX:  w_state_next = S_DONE;
                S_DONE: if (out_ready) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_neg <= w_res_neg;
                        r_cnt <= CNT_W'(XLEN);
                        r_hi  <= '0;
                        if (w_is_div) begin
                            r_lo   <= w_abs_a;
                            r_opnd <= w_abs_b;
                        end else begin
                            r_lo   <= w_abs_b;
                            r_opnd <= w_abs_a;
                        end
                        if (w_fast) begin
                            r_result <= w_fast_res;
                        end else if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_op[2]) begin
                        r_lo <= {r_lo[XLEN-2:0], ~w_div_diff[XLEN]};
                        r_hi <= w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0];
                    end else begin
                        r_hi <= w_mul_sum[XLEN:1];
                        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit (XLEN=32). Expected
//               results and latencies are queued when a request is issued and
//               popped when the response appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] c_min = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int last_wait;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t mul_vec[4] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}
    };

    vec_t div_vec[4] = '{
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'd5, 32'd100,       32'd7,         32'd14},
        '{3'd7, 32'd100,       32'd7,         32'd2}
    };

    vec_t spc_vec[5] = '{
        '{3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF},
        '{3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
        '{3'd1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000}
    };

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model of the eight RV32M operations.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic        [63:0] ua;
        logic        [63:0] ub;
        logic        [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (o)
            3'd0: begin p = ua * ub;             return p[31:0];  end
            3'd1: begin p = sa * sb;             return p[63:32]; end
            3'd2: begin p = sa * $signed(ub);    return p[63:32]; end
            3'd3: begin p = ua * ub;             return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == c_min && b == 32'hFFFF_FFFF) return c_min;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin
                if (b == 0) return a;
                if (a == c_min && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Clock edges between the accept edge and the first cycle with out_valid.
    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        if (o[2]) begin
            if (b == 0) return 0;
            if (!o[0] && a == c_min && b == 32'hFFFF_FFFF) return 0;
            return XLEN + 1;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 0;
`else
        if (a == 0 || b == 0) return 0;
        return XLEN + 1;
`endif
    endfunction

    // Present a request, wait for in_ready (bounded), let it be accepted, then
    // scramble the inputs so any late sampling shows up as a wrong result.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e);
        exp_q.push_back(e);
        lat_q.push_back(exp_lat(o, a, b));
        op       = o;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        last_wait = 0;
        while (!in_ready && last_wait < 200) begin
            @(posedge clk); #1;
            last_wait++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_ready: in_ready=%b required=1 after %0d cycles", in_ready, last_wait);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        src_a    = $urandom;
        src_b    = $urandom;
        op       = 3'($urandom_range(0, 7));
    endtask

    // Wait (bounded) for out_valid; report observed value and latency.
    task automatic wait_out(output logic [31:0] r, output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = out_valid;
        r  = result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset: in_ready/out_valid/busy=%b result=%h required 100 and 0",
                     {in_ready, out_valid, busy}, result);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset: in_ready/out_valid/busy=%b required 100",
                     {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_mul();
        logic [31:0] r, e;
        int lat, el;
        bit ok;
        foreach (mul_vec[i]) begin
            issue(mul_vec[i].op, mul_vec[i].a, mul_vec[i].b, mul_vec[i].e);
            wait_out(r, lat, ok);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++;
            if (!ok || r !== e) begin
                errors++;
                $display("FAIL mul[%0d] op=%0d: result=%h required=%h", i, mul_vec[i].op, r, e);
            end
            checks++;
            if (lat != el) begin
                errors++;
                $display("FAIL mul_lat[%0d]: latency=%0d required=%0d", i, lat, el);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div();
        logic [31:0] r, e;
        int lat, el;
        bit ok;
        foreach (div_vec[i]) begin
            issue(div_vec[i].op, div_vec[i].a, div_vec[i].b, div_vec[i].e);
            wait_out(r, lat, ok);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++;
            if (!ok || r !== e) begin
                errors++;
                $display("FAIL div[%0d] op=%0d: result=%h required=%h", i, div_vec[i].op, r, e);
            end
            checks++;
            if (lat != el) begin
                errors++;
                $display("FAIL div_lat[%0d]: latency=%0d required=%0d", i, lat, el);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_special();
        logic [31:0] r, e;
        int lat, el;
        bit ok;
        foreach (spc_vec[i]) begin
            issue(spc_vec[i].op, spc_vec[i].a, spc_vec[i].b, spc_vec[i].e);
            wait_out(r, lat, ok);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++;
            if (!ok || r !== e || lat != el) begin
                errors++;
                $display("FAIL special[%0d] op=%0d: result=%h lat=%0d required=%h lat=%0d",
                         i, spc_vec[i].op, r, lat, e, el);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [31:0] r, e, a, b;
        logic [2:0]  o;
        int lat, el;
        bit ok;
        for (int i = 0; i < 10; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            issue(o, a, b, model(o, a, b));
            wait_out(r, lat, ok);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++;
            if (!ok || r !== e || lat != el) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: result=%h lat=%0d required=%h lat=%0d",
                         i, o, a, b, r, lat, e, el);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, e;
        int lat, el;
        bit ok;
        int bad;
        out_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        wait_out(r, lat, ok);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (!ok || r !== e) begin
            errors++;
            $display("FAIL hold_first: result=%h required=%h", r, e);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!out_valid || result !== e || in_ready || !busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (!in_ready || out_valid) begin
            errors++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, e;
        int lat, el;
        bit ok;
        issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        wait_out(r, lat, ok);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (!ok || r !== e || in_ready) begin
            errors++;
            $display("FAIL b2b_first: result=%h in_ready=%b required=%h 0", r, in_ready, e);
        end
        issue(3'd7, 32'd5, 32'd0, 32'd5);
        checks++;
        if (last_wait != 1) begin
            errors++;
            $display("FAIL b2b_gap: idle gap=%0d required=1", last_wait);
        end
        wait_out(r, lat, ok);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (!ok || r !== e || lat != el) begin
            errors++;
            $display("FAIL b2b_second: result=%h required=%h", r, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [31:0] r, e;
        int lat, el;
        bit ok;
        int seen;
        // Flush mid-CALC: accept at T, flush during cycle T+5.
        issue(3'd4, 32'd1000, 32'd3, 32'd333);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(exp_q.pop_front()); void'(lat_q.pop_front());
        checks++;
        if (!in_ready || busy || out_valid) begin
            errors++;
            $display("FAIL flush_calc: in_ready/busy/out_valid=%b%b%b required 100", in_ready, busy, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_valid: out_valid seen %0d cycles required 0", seen);
        end
        issue(3'd5, 32'd9, 32'd3, 32'd3);
        wait_out(r, lat, ok);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (!ok || r !== e || lat != el) begin
            errors++;
            $display("FAIL flush_after: result=%h lat=%0d required=%h lat=%0d", r, lat, e, el);
        end
        @(posedge clk); #1;
        // Flush with in_valid in IDLE: request must not be taken.
        op = 3'd5; src_a = 32'd8; src_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy || !in_ready) begin
            errors++;
            $display("FAIL flush_idle: busy=%b in_ready=%b required 0 1", busy, in_ready);
        end
        // Flush in DONE: out_valid drops, result retained.
        issue(3'd5, 32'd77, 32'd0, 32'hFFFF_FFFF);
        void'(exp_q.pop_front()); void'(lat_q.pop_front());
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (out_valid || result !== 32'hFFFF_FFFF || !in_ready) begin
            errors++;
            $display("FAIL flush_done: out_valid=%b result=%h in_ready=%b required 0 ffffffff 1",
                     out_valid, result, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        issue(3'd5, 32'd50, 32'd7, 32'd7);
        void'(exp_q.pop_front()); void'(lat_q.pop_front());
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: in_ready/out_valid/busy=%b result=%h required 100 and 0",
                     {in_ready, out_valid, busy}, result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        src_a     = '0;
        src_b     = '0;
        out_ready = 1'b1;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative RV32M/RV64M multiply/divide execution unit, next generation of the fixed 32-bit M-extension decode in the common package.
- Sits beside the integer ALU in EX. Accepts one operation at a time via valid/ready, computes over multiple cycles and returns one result via valid/ready.
- Handles all eight M-extension ops plus RISC-V divide-by-zero and signed-overflow rules. Pipeline flush is supported.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  abort in-flight op; synchronous, priority over all else
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept (high only in IDLE)
- op  in  3  MUL_DIV_t encoding: MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7
- src_a  in  XLEN  rs1 operand (multiplicand/dividend)
- src_b  in  XLEN  rs2 operand (multiplier/divisor)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result value
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; busy=0; counter and datapath registers 0.
- Signed ops latch operand magnitudes and a result-sign flag at accept:
  - MULH: sign = a[MSB]^b[MSB]; both operands signed.
  - MULHSU: sign = a[MSB]; a signed, b unsigned.
  - DIV: quotient sign = a^b; REM: remainder sign = sign of a.
- States:
  - IDLE: in_valid && in_ready accepts (cycle T). Special case -> DONE, else -> CALC with counter=XLEN.
  - CALC: one radix-2 step per cycle; counter decrements; at counter==1 -> FIX. Exactly XLEN cycles.
  - FIX: conditional two's-complement negate; select low half (MUL), high half (MULH*), quotient or remainder -> DONE.
  - DONE: out_valid=1, result stable. Leave to IDLE when out_ready=1; hold indefinitely otherwise.
- Multiply: shift-add on 2*XLEN accumulator over unsigned magnitudes; negate full 2*XLEN product in FIX when sign flag set.
- Divide: restoring, unsigned magnitudes. Each step shifts the remainder left, brings in the next dividend bit and trial-subtracts.
- Latency, normal op: accept at T -> out_valid at T+XLEN+2.
- Special cases (no CALC), out_valid at T+1:
  - DIV/DIVU, b==0: quotient = all ones.
  - REM/REMU, b==0: remainder = a.
  - DIV, a==MIN and b==-1: quotient = MIN. REM, same operands: remainder = 0.
  - Any MUL op, a==0 or b==0: result 0.
- Back-to-back: in_ready rises the cycle after the DONE handshake, so the minimum gap between accepts is 1 idle cycle.
- flush:
  - Any state -> IDLE next cycle; out_valid=0; result retained but invalid.
  - flush with in_valid in IDLE: request is not accepted.
  - flush in DONE with out_ready=1: result is discarded.
- Inputs are sampled only at accept; changes to src_a/src_b/op afterwards are ignored.
- Illegal XLEN: elaboration-time $error.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle combinational XLEN x XLEN signed-extended product, registered into result.
  - Path is IDLE -> DONE, out_valid at T+1.
  - Divide ops are unchanged.
- Undefined: multiplies use the iterative path, latency XLEN+2. No multiplier array is synthesised.
- Results must be bit-identical in both builds.

Test Plan:
- XLEN=32, MUL a=7 b=0xFFFFFFFD -> result 0xFFFFFFEB at T+34 (T+1 with MULDIV_FAST_MUL_EN).
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. All at T+34.
- DIVU a=0x1234 b=0 -> 0xFFFFFFFF at T+1; REMU a=0x1234 b=0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Hold out_ready=0 for 10 cycles after out_valid -> result and out_valid stable, in_ready=0. Release -> next cycle in_ready=1.
- Assert flush at T+5 of a DIV -> out_valid never rises; in_ready=1 at T+6. A new DIVU 9/3 accepted then returns 3. Assert rst mid-CALC -> all outputs return to reset values immediately.
